input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions the asynchronous single-bit input that drives `state_machine`'s `in_i` pin. It synchronises the raw signal into the `clk_i` domain and rejects glitches shorter than a programmable number of sample periods. It outputs a clean level plus single-cycle rise/fall pulses. It sits directly upstream of `state_machine`: `level_o` connects to `in_i`.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the synchroniser chain; legal values are ≥2.
- `STABLE_CYCLES`, default 4: consecutive enabled samples that must disagree with `level_o` before it toggles; legal values are ≥2.
- `RESET_LEVEL`, default 1'b0: value loaded into the synchroniser and `level_o` on reset.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `raw_i`  in  1  asynchronous raw input (button/switch).
- `sample_en_i`  in  1  sample qualifier; tie to 1 to sample every clock.
- `level_o`  out  1  debounced level; feeds `state_machine.in_i`.
- `rise_o`  out  1  one-cycle pulse on a 0→1 transition of `level_o`.
- `fall_o`  out  1  one-cycle pulse on a 1→0 transition of `level_o`.
- `busy_o`  out  1  high while a candidate transition is being counted.

## Operation
- **Synchroniser**
  - Chain of `SYNC_STAGES` registers, clocked every cycle and not gated by `sample_en_i`.
  - The last stage is the synced sample `s`.
- **Counter**: `cnt` has width `$clog2(STABLE_CYCLES)`. No arithmetic wraps: `cnt` never exceeds `STABLE_CYCLES-1`.
- **FSM states**: IDLE and COUNT. The FSM and `cnt` update only when `sample_en_i`=1. When `sample_en_i`=0 they hold, and the pulses are 0.
- **IDLE**
  - If `s` != `level_o`: go to COUNT with `cnt`=1.
  - Otherwise stay in IDLE with `cnt`=0.
- **COUNT, `s` == `level_o`**: glitch rejected. Go to IDLE with `cnt`=0, no pulse.
- **COUNT, `s` != `level_o` and `cnt` < `STABLE_CYCLES-1`**: `cnt`++.
- **COUNT, `s` != `level_o` and `cnt` == `STABLE_CYCLES-1`** (commit):
  - `level_o` <= `s`.
  - `rise_o` or `fall_o` goes high for exactly one cycle, per direction.
  - Go to IDLE with `cnt`=0.
- **Pulse rules**
  - The pulse is registered and coincides with the first cycle of the new `level_o` value.
  - `rise_o` and `fall_o` are never both high.
- **`busy_o`**: equals (state == COUNT), registered.
- **Reset** (`reset_i`=1 at an edge):
  - Synchroniser stages and `level_o` = `RESET_LEVEL`.
  - `rise_o`=`fall_o`=`busy_o`=0, `cnt`=0, state IDLE.
  - Reset overrides `sample_en_i` and any in-progress count. A reset mid-count discards the count and produces no pulse.

## Timing
- Edge numbering: `raw_i` changes before edge E0 and is held.
  - E0: the first synchroniser stage captures it.
  - E(`SYNC_STAGES`-1): `s` reflects it.
- **Latency** with `sample_en_i`=1: `level_o` toggles at edge E(`SYNC_STAGES`+`STABLE_CYCLES`-1). With defaults this is E5.
- **`busy_o`** is high after edges E(`SYNC_STAGES`) … E(`SYNC_STAGES`+`STABLE_CYCLES`-2), and low after the commit edge.
- **Minimum accepted pulse width**: `STABLE_CYCLES` enabled samples. Shorter excursions never reach `level_o`.
- **Gated sampling**: with `sample_en_i` gated, latency counts enabled sample cycles, not clocks. Synchroniser delay is unchanged.
- **`state_machine` timing**: `level_o` is a plain register output. `state_machine` sees the new value at the edge after the commit edge.

## Test plan
Defaults throughout (`SYNC_STAGES`=2, `STABLE_CYCLES`=4, `RESET_LEVEL`=0), 100-unit clock, `sample_en_i`=1 unless stated.
1. Reset: hold `reset_i`=1 for 2 cycles with `raw_i`=1, release before edge R → `level_o`, `rise_o`, `fall_o`, `busy_o` all 0 during reset. `level_o`=1 after R+5, with `rise_o`=1 for that single cycle only.
2. Clean rise: `raw_i` 0→1 before E0 → `busy_o`=1 after E2, E3, E4. After E5: `level_o`=1, `rise_o`=1 for one cycle, `busy_o`=0. After E6: `rise_o`=0.
3. Glitch rejection: `raw_i`=1 for exactly 3 cycles, then 0 → `busy_o` rises then returns to 0. `level_o` stays 0; `rise_o` and `fall_o` never assert.
4. Clean fall from `level_o`=1: `raw_i` 1→0 before E0 → `level_o`=0 and `fall_o`=1 for one cycle after E5. `rise_o` stays 0.
5. Gated sampling: `sample_en_i` alternating 1,0,1,0…, `raw_i` 0→1 → `level_o` toggles only after 4 enabled samples of `s`=1. `cnt`/state hold on `sample_en_i`=0 cycles, and no pulse appears on a disabled cycle.
6. Reset mid-count: `raw_i` 0→1, assert `reset_i` at E3 (`busy_o`=1) for one cycle, with `raw_i` back to 0 → after E3: `busy_o`=0, `level_o`=0. No `rise_o` at any time.

Source files
------------

// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_if
// Description : Signal bundle between a raw-input source and the debouncer.
//               The master drives the raw level and sample qualifier; the
//               slave (the debouncer) returns the clean level and edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_debouncer_if;
    logic raw_i;
    logic sample_en_i;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    modport master (
        output raw_i,
        output sample_en_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  busy_o
    );

    modport slave (
        input  raw_i,
        input  sample_en_i,
        output level_o,
        output rise_o,
        output fall_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronises an asynchronous single-bit input and only lets a
//               new level through once it has been seen for STABLE_CYCLES
//               consecutive enabled samples. Emits one-cycle rise/fall pulses
//               aligned with the first cycle of the new level.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input_debouncer_if.slave bus
);

    localparam int unsigned      c_cnt_w    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_CYCLES - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_count = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [0:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_s;
    logic                   w_differ;

    // Last synchroniser stage is the sample the filter works on; a
    // candidate transition exists whenever it disagrees with the output.
    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_s != r_level);

    // Metastability chain, free-running regardless of the sample qualifier.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_i};
        end
    end

    // Stability filter: count consecutive disagreeing samples, commit the
    // new level on the last one, and drop back to idle on any agreement.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
            r_cnt   <= c_cnt_zero;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            // Pulses last one clock; disabled cycles never carry a pulse.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (bus.sample_en_i) begin
                if (r_state == c_st_idle) begin
                    if (w_differ) begin
                        r_state <= c_st_count;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_cnt   <= c_cnt_zero;
                    end
                end else begin
                    if (!w_differ) begin
                        // Excursion ended early: glitch, discard it.
                        r_state <= c_st_idle;
                        r_cnt   <= c_cnt_zero;
                    end else if (r_cnt == c_cnt_max) begin
                        r_level <= w_s;
                        r_rise  <= w_s;
                        r_fall  <= ~w_s;
                        r_state <= c_st_idle;
                        r_cnt   <= c_cnt_zero;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
            end
        end
    end

    assign bus.level_o = r_level;
    assign bus.rise_o  = r_rise;
    assign bus.fall_o  = r_fall;
    assign bus.busy_o  = (r_state == c_st_count);

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed self-checking bench for input_debouncer with default
//               parameters. Each cycle compares {level,rise,fall,busy}
//               against hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    input_debouncer_if bus ();

    input_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .RESET_LEVEL   (1'b0)
    ) u_dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #50 clk_i = ~clk_i;

    // Reset held with raw high, then the high level is accepted after R+5.
    task automatic test_reset();
        logic [3:0] obs;
        logic [3:0] exp_v;
        reset_i         = 1'b1;
        bus.raw_i       = 1'b1;
        bus.sample_en_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            obs = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold c%0d: {level,rise,fall,busy}=%b expected 0000", k, obs);
            end
        end
        reset_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_i); #1;
            exp_v = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_release R+%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
    endtask

    // Level 1 -> 0 with a single fall pulse after E5.
    task automatic test_fall();
        logic [3:0] obs;
        logic [3:0] exp_v;
        bus.raw_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_i); #1;
            exp_v = {(k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL fall E%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
    endtask

    // Three-cycle high pulse is one sample short and must be rejected.
    task automatic test_glitch();
        logic [3:0] obs;
        logic [3:0] exp_v;
        for (int k = 0; k < 10; k++) begin
            bus.raw_i = (k < 3);
            @(posedge clk_i); #1;
            exp_v = {1'b0, 1'b0, 1'b0, (k >= 2 && k <= 4)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL glitch E%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
    endtask

    // Level 0 -> 1 with a single rise pulse after E5, gone after E6.
    task automatic test_rise();
        logic [3:0] obs;
        logic [3:0] exp_v;
        bus.raw_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_i); #1;
            exp_v = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rise E%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
    endtask

    // Sampling enabled on even edges only: commit lands on E8.
    task automatic test_gated();
        logic [3:0] obs;
        logic [3:0] exp_v;
        reset_i   = 1'b1;
        bus.raw_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i   = 1'b0;
        bus.raw_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.sample_en_i = (k % 2 == 0);
            @(posedge clk_i); #1;
            exp_v = {(k >= 8), (k == 8), 1'b0, (k >= 2 && k <= 7)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL gated E%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
        bus.sample_en_i = 1'b1;
    endtask

    // Reset at E3 while counting discards the candidate without a pulse.
    task automatic test_reset_mid_count();
        logic [3:0] obs;
        logic [3:0] exp_v;
        reset_i   = 1'b1;
        bus.raw_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i   = 1'b0;
        bus.raw_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            exp_v = {3'b000, (k == 2)};
            obs   = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL midreset_pre E%0d: {level,rise,fall,busy}=%b expected %b", k, obs, exp_v);
            end
        end
        reset_i   = 1'b1;
        bus.raw_i = 1'b0;
        for (int k = 3; k < 10; k++) begin
            @(posedge clk_i); #1;
            reset_i = 1'b0;
            obs     = {bus.level_o, bus.rise_o, bus.fall_o, bus.busy_o};
            n_vec++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL midreset_post E%0d: {level,rise,fall,busy}=%b expected 0000", k, obs);
            end
        end
    endtask

    initial begin
        bus.raw_i       = 1'b0;
        bus.sample_en_i = 1'b1;
        test_reset();
        test_fall();
        test_glitch();
        test_rise();
        test_gated();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
